// File: rtl/int_pkg.sv
// Shared definitions for the external-interrupt arbiter: register offsets,
// arbiter state encoding and the reserved "no source" ID.
package int_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_CLAIM   = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIGNAL  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int NO_ID = 0;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate the request vector so ptr lands at bit 0, take the
// lowest set bit, and map it back to an absolute index.
module rr_priority_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 5
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    grant = '0;
    sum   = '0;
    // Descending scan so the smallest rotated offset is the one that sticks.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IDX_W + 1)'(k);
        if (sum >= (IDX_W + 1)'(N))
          sum = sum - (IDX_W + 1)'(N);
        grant = sum[IDX_W-1:0];
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/ext_int_arbiter.sv
// External-interrupt arbiter: edge-latched pending bits, enable mask,
// round-robin selection and a claim/complete handshake driving m_ext_int.
module ext_int_arbiter
  import int_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [3:0]         bus_addr,
  input  logic               bus_wr,
  input  logic               bus_rd,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               m_ext_int,
  output logic               busy
);

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] pending, enable, src_prev, cand, edge_det, claim_clr;
  logic [ID_W-1:0]    rr_ptr, claimed_id, sel, sel_id, ptr_nxt;
  logic [1:0]         reg_sel;
  logic               any, claim_fire, complete_ok, wr_enable;
  logic [31:0]        rd_val;
  logic               unused_bits;

  assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata};

  assign reg_sel  = bus_addr[3:2];
  assign cand     = pending & enable;
  assign edge_det = src_irq & ~src_prev;

  rr_priority_pick #(
    .N     (NUM_SRC),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .grant (sel),
    .valid (any)
  );

  assign sel_id  = sel + ID_W'(1);
  assign ptr_nxt = (sel_id == ID_W'(NUM_SRC)) ? '0 : sel_id;

  // A claim only takes effect while signalling with a live candidate; an
  // enable write landing the same cycle is not yet visible in cand.
  assign claim_fire  = bus_rd && (reg_sel == REG_CLAIM) && (state == SIGNAL) && any;
  assign complete_ok = bus_wr && (reg_sel == REG_CLAIM) && (state == SERVICE) &&
                       (bus_wdata[ID_W-1:0] == claimed_id);
  assign wr_enable   = bus_wr && (reg_sel == REG_ENABLE);
  assign claim_clr   = claim_fire ? (NUM_SRC'(1) << sel) : '0;

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = SIGNAL;
      SIGNAL:  if (claim_fire) state_nxt = SERVICE;
               else if (!any) state_nxt = IDLE;
      SERVICE: if (complete_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ext_int = (state == SIGNAL);
    busy      = (state == SERVICE);
  end

  // New edges win over the claim clear on the same source.
  always_ff @(posedge CLK) begin
    src_prev <= src_irq;
    if (RST) begin
      pending    <= '0;
      enable     <= '0;
      rr_ptr     <= '0;
      claimed_id <= ID_W'(NO_ID);
    end else begin
      pending <= (pending & ~claim_clr) | edge_det;
      if (wr_enable)
        enable <= bus_wdata[NUM_SRC-1:0];
      if (claim_fire) begin
        rr_ptr     <= ptr_nxt;
        claimed_id <= sel_id;
      end else if (complete_ok) begin
        claimed_id <= ID_W'(NO_ID);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      REG_PENDING: rd_val[NUM_SRC-1:0] = pending;
      REG_ENABLE:  rd_val[NUM_SRC-1:0] = enable;
      REG_CLAIM:   if (claim_fire) rd_val[ID_W-1:0] = sel_id;
      REG_STATUS:  rd_val[2:0] = {state, m_ext_int};
      default:     rd_val = '0;
    endcase
  end

  // Read data reflects pre-write state and holds until the next read.
  always_ff @(posedge CLK) begin
    if (RST)
      bus_rdata <= '0;
    else if (bus_rd)
      bus_rdata <= rd_val;
  end

endmodule

// File: tb/tb_ext_int_arbiter.sv
// Bench for ext_int_arbiter: directed scenarios plus random traffic, scored
// against an abstract per-cycle model of pending/enable/claim behaviour.
module tb_ext_int_arbiter;
  localparam int N  = 8;
  localparam int IW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  src_irq;
  logic [3:0]    bus_addr;
  logic          bus_wr, bus_rd;
  logic [31:0]   bus_wdata, bus_rdata;
  logic          m_ext_int, busy;

  always #5 CLK = ~CLK;

  ext_int_arbiter #(.NUM_SRC(N), .ID_W(IW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .src_irq   (src_irq),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .m_ext_int (m_ext_int),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 signalling, 2 in service.
  bit [N-1:0]  m_pend, m_en, m_prev;
  int          m_ptr, m_cid, m_ph;
  bit          m_rd_done = 1'b0;
  bit          mon_on    = 1'b0;
  logic [31:0] exp_q[$];
  bit [N-1:0]  cur_src = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_on) begin
      chk("m_ext_int", 32'(m_ext_int), 32'(m_ph == 1));
      chk("busy", 32'(busy), 32'(m_ph == 2));
      if (m_rd_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rdata_no_expectation actual=%h required=none", bus_rdata);
        end else begin
          chk("bus_rdata", bus_rdata, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(bit rst, bit [N-1:0] src, bit rd, bit wr, int addr, logic [31:0] wd);
    bit [N-1:0]  cand, n_pend, n_en, edges;
    int          sel, n_ptr, n_cid, n_ph;
    bit          any, claim, compl;
    logic [31:0] rv;
    @(negedge CLK);
    RST       = rst;
    src_irq   = src;
    bus_rd    = rd;
    bus_wr    = wr;
    bus_addr  = {2'(addr), 2'($urandom_range(0, 3))};
    bus_wdata = wd;
    n_pend = '0; n_en = '0; n_ptr = 0; n_cid = 0; n_ph = 0;
    if (!rst) begin
      cand = m_pend & m_en;
      any  = (cand != 0);
      sel  = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (sel < 0 && cand[i]) sel = i;
      end
      claim = rd && addr == 2 && m_ph == 1 && any;
      compl = wr && addr == 2 && m_ph == 2 && int'(wd[IW-1:0]) == m_cid;
      if (rd) begin
        case (addr)
          0:       rv = 32'(m_pend);
          1:       rv = 32'(m_en);
          2:       rv = claim ? 32'(sel + 1) : 32'd0;
          default: rv = {29'b0, 2'(m_ph), (m_ph == 1)};
        endcase
        exp_q.push_back(rv);
      end
      edges  = src & ~m_prev;
      n_pend = m_pend;
      if (claim) n_pend[sel] = 1'b0;
      n_pend = n_pend | edges;
      n_en   = (wr && addr == 1) ? wd[N-1:0] : m_en;
      n_ptr  = claim ? (sel + 1) % N : m_ptr;
      n_cid  = claim ? sel + 1 : (compl ? 0 : m_cid);
      case (m_ph)
        0:       n_ph = any ? 1 : 0;
        1:       n_ph = claim ? 2 : (any ? 1 : 0);
        default: n_ph = compl ? 0 : 2;
      endcase
    end
    @(posedge CLK);
    m_pend = n_pend; m_en = n_en; m_ptr = n_ptr; m_cid = n_cid; m_ph = n_ph;
    m_prev = src;
    m_rd_done = rd && !rst;
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) step(1'b0, cur_src, 1'b0, 1'b0, 0, 32'd0);
  endtask
  task automatic rd(int a);
    step(1'b0, cur_src, 1'b1, 1'b0, a, 32'd0);
  endtask
  task automatic wr(int a, logic [31:0] d);
    step(1'b0, cur_src, 1'b0, 1'b1, a, d);
  endtask
  task automatic pulse(bit [N-1:0] m);
    cur_src = cur_src | m;
    idle(1);
    cur_src = cur_src & ~m;
  endtask
  task automatic do_reset();
    step(1'b1, cur_src, 1'b0, 1'b0, 0, 32'd0);
  endtask

  initial begin
    RST = 1'b1; src_irq = '0; bus_addr = '0; bus_wr = 1'b0; bus_rd = 1'b0; bus_wdata = '0;
    do_reset();
    do_reset();
    mon_on = 1'b1;
    #1 chk("rdata_after_reset", bus_rdata, 32'd0);

    // Basic claim/complete on source 0.
    wr(1, 32'h01); pulse(8'h01); idle(1);
    rd(2); idle(1); wr(2, 32'd1); rd(3); idle(1);

    // Round-robin across sources 2 and 5, then wrap.
    wr(1, 32'hFF); pulse(8'h24); idle(2);
    rd(2); wr(2, 32'd3); idle(1);
    rd(2); wr(2, 32'd6);
    pulse(8'h24); idle(2);
    rd(2); wr(2, 32'd3); idle(1); rd(2); wr(2, 32'd6); idle(1);

    // Masking, and enable withdrawn before the claim.
    wr(1, 32'h00); pulse(8'h10); idle(2); rd(0); rd(3);
    wr(1, 32'h10); idle(1); wr(1, 32'h00); idle(1); rd(2); rd(3);
    wr(1, 32'h10); idle(2); rd(2); wr(2, 32'd5); idle(1);

    // Mismatched complete is ignored.
    wr(1, 32'h01); pulse(8'h01); idle(2);
    rd(2); wr(2, 32'd2); idle(1); rd(3); wr(2, 32'd1); idle(1);

    // New edge on the source being claimed keeps it pending.
    pulse(8'h01); idle(2);
    cur_src[0] = 1'b1; rd(2); cur_src[0] = 1'b0;
    rd(0); wr(2, 32'd1); idle(2); rd(2); wr(2, 32'd1); idle(1);

    // Reset during service; a held-high line yields no edge afterwards.
    wr(1, 32'hFF); pulse(8'h04); idle(2); rd(2);
    cur_src[7] = 1'b1; idle(1);
    do_reset();
    #1 chk("rdata_mid_reset", bus_rdata, 32'd0);
    idle(3); rd(0); rd(1); rd(3);
    cur_src = '0; idle(1);

    // Random traffic.
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) cur_src = cur_src ^ N'(1 << $urandom_range(0, N - 1));
      if (r < 2)       do_reset();
      else if (r < 30) rd($urandom_range(0, 3));
      else if (r < 42) wr(1, $urandom);
      else if (r < 58) wr(2, ($urandom_range(0, 1) == 1) ?
                          {$urandom_range(0, 1) == 1 ? 27'h5A5A5A5 : 27'h0, 5'(m_cid)} :
                          32'($urandom));
      else if (r < 66) step(1'b0, cur_src, 1'b1, 1'b1, $urandom_range(0, 3), $urandom);
      else if (r < 70) wr(($urandom_range(0, 1) == 1) ? 0 : 3, $urandom);
      else             idle(1);
    end

    idle(1);
    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
